// File: rtl/instr_fetch_queue_pkg.sv
// rtl/instr_fetch_queue_pkg.sv - shared opcode constant and fetch FSM state type
package instr_fetch_queue_pkg;

  localparam logic [5:0] OPC_HALT = 6'b111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  function automatic logic is_halt(input logic [5:0] opc);
    return opc == OPC_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// rtl/instr_fetch_queue_fetch_fifo.sv - {pc, instr} buffer with flush and occupancy count
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  assign head_data = mem[rd_ptr[PTR_W-1:0]];
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetch stage: PC, single-outstanding imem reads, decode FIFO
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        boot_pc,
  input  logic                     start,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_rvalid,
  input  logic [DATA_W-1:0]        imem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     dec_valid,
  output logic [DATA_W-1:0]        dec_instr,
  output logic [ADDR_W-1:0]        dec_pc,
  input  logic                     dec_ready,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [ADDR_W-1:0]   req_addr;
  logic                inflight;
  logic                drop;

  logic                redirect_act;
  logic                push;
  logic                pop;
  logic                push_halt;
  logic                head_halt;
  logic                fifo_empty;
  logic                fifo_full;
  logic [ADDR_W+DATA_W-1:0] head_data;
  logic [ADDR_W-1:0]   head_pc;
  logic [DATA_W-1:0]   head_instr;

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({req_addr, imem_rdata}),
    .pop       (pop),
    .flush     (redirect_act),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign head_pc    = head_data[ADDR_W+DATA_W-1:DATA_W];
  assign head_instr = head_data[DATA_W-1:0];
  assign head_halt  = is_halt(head_instr[DATA_W-1 -: 6]);
  assign push_halt  = push && is_halt(imem_rdata[DATA_W-1 -: 6]);

  assign redirect_act = redirect_valid && (state_q == FETCH || state_q == DRAIN);

  assign dec_valid = !fifo_empty && (state_q != HALTED);
  assign dec_pc    = dec_valid ? head_pc : '0;
  assign dec_instr = dec_valid ? head_instr : '0;
  assign halted    = (state_q == HALTED);

  // A dropped response frees its slot this cycle, so a redirected fetch may issue alongside it.
  assign imem_req  = (state_q == FETCH) && !redirect_act && (!inflight || drop) && !fifo_full;
  assign imem_addr = fetch_pc;

  assign pop  = dec_valid && dec_ready && !redirect_act;
  assign push = imem_rvalid && inflight && !drop && (state_q == FETCH) && !redirect_act;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (redirect_act) state_d = FETCH;
               else if (push_halt) state_d = DRAIN;
      DRAIN:   if (redirect_act) state_d = FETCH;
               else if (pop && head_halt) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fetch_pc <= '0;
      req_addr <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && start) fetch_pc <= boot_pc;
      else if (redirect_act)        fetch_pc <= redirect_pc;
      else if (imem_req)            fetch_pc <= fetch_pc + ADDR_W'(1);

      if (imem_req) begin
        inflight <= 1'b1;
        req_addr <= fetch_pc;
      end else if (imem_rvalid) begin
        inflight <= 1'b0;
      end

      // A response landing in the redirect cycle is simply not enqueued; only later ones need drop.
      if (redirect_act)     drop <= inflight && !imem_rvalid;
      else if (imem_rvalid) drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] boot_pc;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic        halted;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int req_cnt = 0;
  int bad_req = 0;
  logic        bad_watch;
  logic        halt_en;
  logic [31:0] halt_addr;
  logic        hchk;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  instr_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .boot_pc        (boot_pc),
    .start          (start),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready),
    .halted         (halted),
    .fifo_count     (fifo_count)
  );

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    logic [5:0] op;
    op = a[5:0] ^ a[11:6];
    if (op == 6'h3F) op = 6'h00;
    if (halt_en && a == halt_addr) op = 6'h3F;
    return {op, a[25:0] ^ 26'h15A5A5A};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_stream(input logic [31:0] base);
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin
      a = base + 32'(i);
      exp_q.push_back(a);
      if (halt_en && a == halt_addr) break;
    end
  endtask

  task automatic start_run(input logic [31:0] pc);
    boot_pc = pc;
    start = 1'b1;
    exp_q.delete();
    push_stream(pc);
    tick(1);
    start = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    exp_q.delete();
    push_stream(pc);
    tick(1);
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    redirect_valid = 1'b0;
    dec_ready = 1'b0;
    exp_q.delete();
    hchk = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Program memory: fixed one-cycle response to every request.
  initial begin
    forever begin
      @(posedge clk);
      imem_rvalid <= imem_req;
      imem_rdata  <= instr_at(imem_addr);
      if (imem_req) begin
        req_cnt <= req_cnt + 1;
        if (bad_watch && imem_addr > halt_addr) bad_req <= bad_req + 1;
      end
    end
  end

  // Monitor: pops the expected stream on every accepted decode handshake.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hchk) begin
          chk("halted_after_pop", 64'(halted), 64'd1);
          chk("dec_valid_after_halt", 64'(dec_valid), 64'd0);
          hchk = 1'b0;
        end
        if (dec_valid && dec_ready && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_dec_pc", 64'(dec_pc), 64'hFFFF_FFFF_0000_0000);
          end else begin
            e = exp_q.pop_front();
            chk("dec_pc", 64'(dec_pc), 64'(e));
            chk("dec_instr", 64'(dec_instr), 64'(instr_at(e)));
            pops++;
            if (halt_en && e == halt_addr) begin
              chk("halted_at_pop", 64'(halted), 64'd0);
              hchk = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    int lat;
    int n;
    int p0;
    int r0;
    rst_n = 1'b0; start = 1'b0; boot_pc = '0; redirect_valid = 1'b0; redirect_pc = '0;
    dec_ready = 1'b0; halt_en = 1'b0; halt_addr = '0; bad_watch = 1'b0; hchk = 1'b0;
    tick(2);
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_dec_pc", 64'(dec_pc), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    rst_n = 1'b1;
    tick(1);

    // Basic stream from 0x10 and first-valid latency.
    dec_ready = 1'b1;
    start_run(32'h10);
    lat = 1;
    while (!dec_valid && lat < 20) begin
      tick(1);
      lat++;
    end
    chk("first_valid_latency", 64'(lat), 64'd3);
    p0 = pops;
    tick(12);
    chk("t1_progress", 64'(pops - p0 >= 5), 64'd1);

    // Backpressure fills the FIFO and stops requests.
    do_reset();
    start_run(32'h10);
    tick(20);
    chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_no_req", 64'(imem_req), 64'd0);
    r0 = req_cnt;
    tick(3);
    chk("full_req_stalled", 64'(req_cnt - r0), 64'd0);
    dec_ready = 1'b1;
    p0 = pops;
    tick(10);
    chk("t2_progress", 64'(pops - p0 >= 4), 64'd1);

    // Redirect with FIFO at 3 and a response arriving.
    dec_ready = 1'b0;
    n = 0;
    while (!(fifo_count == 3'd3 && imem_rvalid) && n < 60) begin
      tick(1);
      n++;
    end
    chk("t3_setup", 64'(fifo_count == 3'd3 && imem_rvalid), 64'd1);
    redirect_to(32'h40);
    chk("redir_flush_count", 64'(fifo_count), 64'd0);
    chk("redir_flush_valid", 64'(dec_valid), 64'd0);
    dec_ready = 1'b1;
    p0 = pops;
    tick(12);
    chk("t3_progress", 64'(pops - p0 >= 4), 64'd1);

    // HALT at 0x12 stops fetch; later start/redirect ignored.
    do_reset();
    halt_en = 1'b1; halt_addr = 32'h12; bad_watch = 1'b1;
    dec_ready = 1'b1;
    start_run(32'h10);
    n = 0;
    while (!halted && n < 60) begin
      tick(1);
      n++;
    end
    chk("halt_reached", 64'(halted), 64'd1);
    chk("halt_stream_done", 64'(exp_q.size()), 64'd0);
    r0 = req_cnt;
    boot_pc = 32'h80; start = 1'b1;
    tick(1);
    start = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h90;
    tick(1);
    redirect_valid = 1'b0;
    tick(6);
    chk("halted_no_req", 64'(req_cnt - r0), 64'd0);
    chk("halted_sticky", 64'(halted), 64'd1);
    chk("halted_no_valid", 64'(dec_valid), 64'd0);
    chk("no_req_past_halt", 64'(bad_req), 64'd0);
    bad_watch = 1'b0;

    // Wrong-path HALT cancelled by redirect before it is popped.
    do_reset();
    start_run(32'h10);
    tick(15);
    chk("drain_count", 64'(fifo_count), 64'd3);
    r0 = req_cnt;
    tick(4);
    chk("drain_no_req", 64'(req_cnt - r0), 64'd0);
    redirect_to(32'h20);
    dec_ready = 1'b1;
    p0 = pops;
    tick(20);
    chk("cancel_not_halted", 64'(halted), 64'd0);
    chk("t5_progress", 64'(pops - p0 >= 6), 64'd1);

    // PC wrap, then reset while a response is pending.
    do_reset();
    halt_en = 1'b0;
    dec_ready = 1'b1;
    start_run(32'hFFFF_FFFF);
    p0 = pops;
    tick(10);
    chk("wrap_progress", 64'(pops - p0 >= 3), 64'd1);
    n = 0;
    while (!imem_req && n < 10) begin
      tick(1);
      n++;
    end
    chk("mid_reset_setup", 64'(imem_req), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(imem_req), 64'd0);
    chk("mid_rst_addr", 64'(imem_addr), 64'd0);
    chk("mid_rst_valid", 64'(dec_valid), 64'd0);
    chk("mid_rst_count", 64'(fifo_count), 64'd0);
    chk("mid_rst_pc", 64'(dec_pc), 64'd0);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    tick(1);
    chk("late_resp_dropped", 64'(fifo_count), 64'd0);
    tick(3);
    chk("idle_no_valid", 64'(dec_valid), 64'd0);
    chk("idle_no_req", 64'(imem_req), 64'd0);

    // Randomized backpressure and redirects.
    do_reset();
    dec_ready = 1'b1;
    start_run($urandom);
    p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      dec_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 3) == 0) redirect_to(32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
        else redirect_to($urandom);
      end else begin
        tick(1);
      end
    end
    chk("random_progress", 64'(pops - p0 >= 200), 64'd1);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
